serial_adder_ctrl: RTL and testbench

Bit-serial add sequencer that sits directly upstream of the 1-bit full adder (`rtl_adder`) and also consumes its outputs. It accepts two N-bit operands plus carry-in and presents one bit pair per clock, LSB first, on the adder's a/b/ci inputs. It registers the adder's sum/co each cycle and returns the N-bit result and carry-out with a one-cycle done pulse. It converts the combinational full adder into an N-bit adder at a cost of N+2 cycles per operation.

---
 rtl/serial_adder_ctrl.sv | 91 +++++++++
 tb/tb_serial_adder_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer for an external 1-bit full adder.
// Feeds one operand bit pair per cycle, LSB first, and collects sum/co into an N-bit result.
module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    input  logic         cin,
    output logic         a,
    output logic         b,
    output logic         ci,
    input  logic         sum,
    input  logic         co,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  shift_a;
    logic [N-1:0]  shift_b;
    logic          carry;
    logic [CW-1:0] count;
    // Bit 0 of the collected sum would only ever hold a stale bit, so it is not stored.
    logic [N-1:1]  sum_shift;
    logic [N-1:0]  sum_next;

    assign sum_next = {sum, sum_shift[N-1:1]};

    // Adder inputs come straight from registers, so there is no loop through the adder.
    assign a    = (state == ADD) & shift_a[0];
    assign b    = (state == ADD) & shift_b[0];
    assign ci   = (state == ADD) & carry;
    assign busy = (state == ADD);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_a   <= '0;
            shift_b   <= '0;
            carry     <= 1'b0;
            count     <= '0;
            sum_shift <= '0;
            result    <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_a <= op_a;
                        shift_b <= op_b;
                        carry   <= cin;
                        count   <= '0;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    shift_a   <= shift_a >> 1;
                    shift_b   <= shift_b >> 1;
                    sum_shift <= sum_next[N-1:1];
                    carry     <= co;
                    count     <= count + 1'b1;
                    if (count == LAST) begin
                        result <= sum_next;
                        cout   <= co;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with N=8, closing the loop through a behavioural full adder.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       cin;
    logic       a;
    logic       b;
    logic       ci;
    logic       sum;
    logic       co;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.N(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .ci     (ci),
        .sum    (sum),
        .co     (co),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    // Combinational 1-bit full adder downstream of the sequencer.
    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (a & ci) | (b & ci);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge, then traces cycles 0..24 after the accepting edge.
    // done_at is the cycle index of the done pulse, -1 if it never came.
    task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                         output int done_at, output int busy_n,
                         output logic [7:0] a_seq, output logic [7:0] b_seq);
        int k;
        k       = 0;
        done_at = -1;
        busy_n  = 0;
        a_seq   = '0;
        b_seq   = '0;
        op_a  = xa;
        op_b  = xb;
        cin   = xc;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            if (busy) begin
                busy_n++;
                if (k < 8) begin
                    a_seq[k] = a;
                    b_seq[k] = b;
                end
                k++;
            end
            if (done) begin
                done_at = cyc;
                break;
            end
            step();
        end
        step();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        op_a  = 8'h12;
        op_b  = 8'h34;
        cin   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({a, b, ci, busy, done, result, cout} !== 13'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got a=%b b=%b ci=%b busy=%b done=%b result=%h cout=%b, want all 0",
                         i, a, b, ci, busy, done, result, cout);
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_start: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_carry_ripple();
        int         done_at;
        int         busy_n;
        logic [7:0] a_seq;
        logic [7:0] b_seq;
        do_op(8'hFF, 8'h01, 1'b0, done_at, busy_n, a_seq, b_seq);
        checks++;
        if (done_at != 8) begin
            errors++;
            $display("FAIL ripple_done_cycle: got %0d, want 8", done_at);
        end
        checks++;
        if (busy_n != 8) begin
            errors++;
            $display("FAIL ripple_busy_cycles: got %0d, want 8", busy_n);
        end
        checks++;
        if (result !== 8'h00 || cout !== 1'b1) begin
            errors++;
            $display("FAIL ripple_result: got %h/%b, want 00/1", result, cout);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || a !== 1'b0 || ci !== 1'b0) begin
            errors++;
            $display("FAIL ripple_idle_after: got busy=%b done=%b a=%b ci=%b, want 0", busy, done, a, ci);
        end
    endtask

    task automatic test_bit_order();
        int         done_at;
        int         busy_n;
        logic [7:0] a_seq;
        logic [7:0] b_seq;
        do_op(8'hA5, 8'h5A, 1'b1, done_at, busy_n, a_seq, b_seq);
        // a presented LSB first: 1,0,1,0,0,1,0,1 ; b: 0,1,0,1,1,0,1,0
        checks++;
        if (a_seq !== 8'b1010_0101) begin
            errors++;
            $display("FAIL order_a_seq: got %b (bit0 first = cycle0), want 10100101", a_seq);
        end
        checks++;
        if (b_seq !== 8'b0101_1010) begin
            errors++;
            $display("FAIL order_b_seq: got %b, want 01011010", b_seq);
        end
        checks++;
        if (result !== 8'h00 || cout !== 1'b1 || done_at != 8) begin
            errors++;
            $display("FAIL order_result: got %h/%b done_at=%0d, want 00/1 done_at=8", result, cout, done_at);
        end
    endtask

    task automatic test_back_to_back();
        int         d0;
        int         d1;
        logic [7:0] r0;
        logic [7:0] r1;
        logic       c0;
        logic       c1;
        int         seen;
        d0 = -1; d1 = -1; r0 = '0; r1 = '0; c0 = 1'b0; c1 = 1'b0; seen = 0;
        op_a  = 8'h01;
        op_b  = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        step();
        op_a = 8'h80;
        op_b = 8'h80;
        for (int cyc = 0; cyc < 30 && seen < 2; cyc++) begin
            if (done) begin
                if (seen == 0) begin
                    d0 = cyc; r0 = result; c0 = cout;
                end else begin
                    d1 = cyc; r1 = result; c1 = cout;
                    start = 1'b0;
                end
                seen++;
            end
            step();
        end
        start = 1'b0;
        repeat (2) step();
        checks++;
        if (d0 != 8 || d1 - d0 != 10) begin
            errors++;
            $display("FAIL b2b_spacing: got done at %0d and %0d, want 8 and 18", d0, d1);
        end
        checks++;
        if (r0 !== 8'h02 || c0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got %h/%b, want 02/0", r0, c0);
        end
        checks++;
        if (r1 !== 8'h00 || c1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got %h/%b, want 00/1", r1, c1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stops: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_ignore_start();
        int done_at;
        done_at = -1;
        op_a  = 8'h3C;
        op_b  = 8'h41;
        cin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            if (cyc == 3) begin
                op_a  = 8'h11;
                op_b  = 8'h22;
                cin   = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_at = cyc;
                break;
            end
            step();
        end
        start = 1'b0;
        checks++;
        if (done_at != 8 || result !== 8'h7D || cout !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: got %h/%b done_at=%0d, want 7D/0 done_at=8", result, cout, done_at);
        end
        repeat (4) step();
        checks++;
        if (busy !== 1'b0 || result !== 8'h7D) begin
            errors++;
            $display("FAIL ignore_no_queue: got busy=%b result=%h, want 0 7D", busy, result);
        end
    endtask

    task automatic test_reset_abort();
        int         seen_done;
        int         done_at;
        int         busy_n;
        logic [7:0] a_seq;
        logic [7:0] b_seq;
        seen_done = 0;
        op_a  = 8'hFF;
        op_b  = 8'hFF;
        cin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        checks++;
        if ({a, b, ci, busy, done, result, cout} !== 13'd0) begin
            errors++;
            $display("FAIL abort_cleared: got a=%b b=%b ci=%b busy=%b done=%b result=%h cout=%b, want all 0",
                     a, b, ci, busy, done, result, cout);
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) seen_done++;
            step();
        end
        checks++;
        if (seen_done != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses busy=%b, want 0 0", seen_done, busy);
        end
        do_op(8'h10, 8'h20, 1'b0, done_at, busy_n, a_seq, b_seq);
        checks++;
        if (result !== 8'h30 || cout !== 1'b0 || done_at != 8) begin
            errors++;
            $display("FAIL abort_recover: got %h/%b done_at=%0d, want 30/0 done_at=8", result, cout, done_at);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        test_reset();
        test_carry_ripple();
        test_bit_order();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
